// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and defaults for the RV32IM fetch PC unit
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BRANCH,
        SEL_TRAP,
        SEL_MRET,
        SEL_PEND
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_PEND
    } pc_state_e;

    // Higher rank wins; non-redirect selections rank zero.
    function automatic logic [1:0] sel_rank(input pc_sel_e sel);
        case (sel)
            SEL_TRAP:   sel_rank = 2'd3;
            SEL_MRET:   sel_rank = 2'd2;
            SEL_BRANCH: sel_rank = 2'd1;
            default:    sel_rank = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pc_unit_redirect_arb.sv
// rtl/pc_unit_redirect_arb.sv - redirect priority select and target alignment check
module pc_redirect_arb #(
    parameter int                XLEN        = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   TRAP_VECTOR = rv_pkg::DEF_TRAP_VECTOR,
    parameter int                ALIGN_CHECK = 1
) (
    input  logic                 i_trap,
    input  logic                 i_mret,
    input  logic                 i_branch,
    input  logic [XLEN-1:0]      i_branch_target,
    input  logic [XLEN-1:0]      i_epc,
    input  logic                 i_pend_valid,
    input  rv_pkg::pc_sel_e      i_pend_sel,
    input  logic [XLEN-1:0]      i_pend_target,
    output rv_pkg::pc_sel_e      o_live_sel,
    output logic [XLEN-1:0]      o_live_target,
    output rv_pkg::pc_sel_e      o_sel,
    output logic [XLEN-1:0]      o_target,
    output logic                 o_misaligned
);
    import rv_pkg::*;

    always_comb begin
        o_live_sel    = SEL_SEQ;
        o_live_target = '0;
        if (i_trap) begin
            o_live_sel    = SEL_TRAP;
            o_live_target = TRAP_VECTOR;
        end else if (i_mret) begin
            o_live_sel    = SEL_MRET;
            o_live_target = i_epc;
        end else if (i_branch) begin
            o_live_sel    = SEL_BRANCH;
            o_live_target = i_branch_target;
        end

        // A latched redirect survives unless a strictly higher live request arrives.
        o_sel    = o_live_sel;
        o_target = o_live_target;
        if (i_pend_valid && (sel_rank(i_pend_sel) >= sel_rank(o_live_sel))) begin
            o_sel    = i_pend_sel;
            o_target = i_pend_target;
        end

        o_misaligned = (ALIGN_CHECK != 0)
                     && ((o_sel == SEL_MRET) || (o_sel == SEL_BRANCH))
                     && (o_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - IF-stage fetch program counter with busy-wait redirect latching
module pc_unit #(
    parameter int                XLEN         = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_VECTOR = rv_pkg::DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = rv_pkg::DEF_TRAP_VECTOR,
    parameter int                INST_BYTES   = 4,
    parameter int                ALIGN_CHECK  = 1
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 BUSYWAIT,
    input  logic                 STALL,
    input  logic                 BRANCH_TAKEN,
    input  logic [XLEN-1:0]      BRANCH_TARGET,
    input  logic                 TRAP,
    input  logic                 MRET,
    input  logic [XLEN-1:0]      EPC,
    output logic [XLEN-1:0]      PC,
    output logic [XLEN-1:0]      PC_PLUS4,
    output logic                 FETCH_VALID,
    output logic                 REDIRECT_PENDING,
    output logic                 MISALIGNED,
    output logic [XLEN-1:0]      BAD_ADDR
);
    import rv_pkg::*;

    pc_state_e          r_state;
    logic [XLEN-1:0]    r_pc;
    pc_sel_e            r_pend_sel;
    logic [XLEN-1:0]    r_pend_target;
    logic               r_misaligned;
    logic [XLEN-1:0]    r_bad_addr;

    pc_sel_e            w_live_sel;
    logic [XLEN-1:0]    w_live_target;
    pc_sel_e            w_sel;
    logic [XLEN-1:0]    w_target;
    logic               w_misaligned;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_pend_valid;

    assign w_pend_valid  = (r_state == ST_PEND);
    assign w_redirect_pc = w_misaligned ? TRAP_VECTOR : w_target;

    pc_redirect_arb #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_arb (
        .i_trap          (TRAP),
        .i_mret          (MRET),
        .i_branch        (BRANCH_TAKEN),
        .i_branch_target (BRANCH_TARGET),
        .i_epc           (EPC),
        .i_pend_valid    (w_pend_valid),
        .i_pend_sel      (r_pend_sel),
        .i_pend_target   (r_pend_target),
        .o_live_sel      (w_live_sel),
        .o_live_target   (w_live_target),
        .o_sel           (w_sel),
        .o_target        (w_target),
        .o_misaligned    (w_misaligned)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend_sel    <= SEL_SEQ;
            r_pend_target <= '0;
            r_misaligned  <= 1'b0;
            r_bad_addr    <= '0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    if (!BUSYWAIT && !STALL) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!BUSYWAIT) begin
                        if (w_sel != SEL_SEQ) begin
                            r_pc <= w_redirect_pc;
                            if (w_misaligned) begin
                                r_misaligned <= 1'b1;
                                r_bad_addr   <= w_target;
                            end
                        end else if (!STALL) begin
                            r_pc <= PC_PLUS4;
                        end
                    end else if (w_live_sel != SEL_SEQ) begin
                        r_pend_sel    <= w_live_sel;
                        r_pend_target <= w_live_target;
                        r_state       <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (BUSYWAIT) begin
                        if (sel_rank(w_live_sel) > sel_rank(r_pend_sel)) begin
                            r_pend_sel    <= w_live_sel;
                            r_pend_target <= w_live_target;
                        end
                    end else begin
                        r_pc <= w_redirect_pc;
                        if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                            r_bad_addr   <= w_target;
                        end
                        r_pend_sel    <= SEL_SEQ;
                        r_pend_target <= '0;
                        r_state       <= ST_RUN;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign PC               = r_pc;
    assign PC_PLUS4         = r_pc + XLEN'(INST_BYTES);
    assign FETCH_VALID      = (r_state == ST_RUN);
    assign REDIRECT_PENDING = w_pend_valid;
    assign MISALIGNED       = r_misaligned;
    assign BAD_ADDR         = r_bad_addr;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized and directed check of pc_unit against a reference model
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        busy, stall, br, trap, mret;
    logic [31:0] bt, epc;

    logic [31:0] o_pc    [2];
    logic [31:0] o_pc4   [2];
    logic        o_fv    [2];
    logic        o_rp    [2];
    logic        o_mis   [2];
    logic [31:0] o_bad   [2];

    int n_cmp;
    int n_fail;

    // Reference state: index 0 has alignment checking, index 1 does not.
    logic [31:0] m_pc       [2];
    bit          m_booted   [2];
    bit          m_pend     [2];
    int          m_pend_rk  [2];
    logic [31:0] m_pend_tgt [2];
    bit          m_mis      [2];
    logic [31:0] m_bad      [2];

    pc_unit #(.ALIGN_CHECK(1)) u_dut (
        .CLOCK(clk), .RESET(rst), .BUSYWAIT(busy), .STALL(stall),
        .BRANCH_TAKEN(br), .BRANCH_TARGET(bt), .TRAP(trap), .MRET(mret), .EPC(epc),
        .PC(o_pc[0]), .PC_PLUS4(o_pc4[0]), .FETCH_VALID(o_fv[0]),
        .REDIRECT_PENDING(o_rp[0]), .MISALIGNED(o_mis[0]), .BAD_ADDR(o_bad[0])
    );

    pc_unit #(.ALIGN_CHECK(0)) u_dut_na (
        .CLOCK(clk), .RESET(rst), .BUSYWAIT(busy), .STALL(stall),
        .BRANCH_TAKEN(br), .BRANCH_TARGET(bt), .TRAP(trap), .MRET(mret), .EPC(epc),
        .PC(o_pc[1]), .PC_PLUS4(o_pc4[1]), .FETCH_VALID(o_fv[1]),
        .REDIRECT_PENDING(o_rp[1]), .MISALIGNED(o_mis[1]), .BAD_ADDR(o_bad[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_pc[a] = 32'h0; m_booted[a] = 0; m_pend[a] = 0; m_pend_rk[a] = 0;
            m_pend_tgt[a] = 32'h0; m_mis[a] = 0; m_bad[a] = 32'h0;
        end
    endtask

    task automatic model_apply(input int a, input int rk, input logic [31:0] t);
        if (a == 0 && rk < 3 && t[1:0] != 2'b00) begin
            m_pc[a] = 32'h100; m_mis[a] = 1; m_bad[a] = t;
        end else begin
            m_pc[a] = t;
        end
    endtask

    task automatic model_step(input int a);
        int          rk;
        logic [31:0] t;
        rk = trap ? 3 : mret ? 2 : br ? 1 : 0;
        t  = trap ? 32'h100 : mret ? epc : bt;
        m_mis[a] = 0;
        if (!m_booted[a]) begin
            if (!busy && !stall) m_booted[a] = 1;
        end else if (!m_pend[a]) begin
            if (!busy) begin
                if (rk > 0) model_apply(a, rk, t);
                else if (!stall) m_pc[a] = m_pc[a] + 32'd4;
            end else if (rk > 0) begin
                m_pend[a] = 1; m_pend_rk[a] = rk; m_pend_tgt[a] = t;
            end
        end else if (busy) begin
            if (rk > m_pend_rk[a]) begin
                m_pend_rk[a] = rk; m_pend_tgt[a] = t;
            end
        end else begin
            if (rk > m_pend_rk[a]) model_apply(a, rk, t);
            else model_apply(a, m_pend_rk[a], m_pend_tgt[a]);
            m_pend[a] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 2; a++) begin
            check($sformatf("%s[%0d].pc", tag, a), o_pc[a], m_pc[a]);
            check($sformatf("%s[%0d].pc4", tag, a), o_pc4[a], m_pc[a] + 32'd4);
            check($sformatf("%s[%0d].fv", tag, a), 32'(o_fv[a]), 32'(m_booted[a] && !m_pend[a]));
            check($sformatf("%s[%0d].rp", tag, a), 32'(o_rp[a]), 32'(m_pend[a]));
            check($sformatf("%s[%0d].mis", tag, a), 32'(o_mis[a]), 32'(m_mis[a]));
            check($sformatf("%s[%0d].bad", tag, a), o_bad[a], m_bad[a]);
        end
    endtask

    task automatic cycle(input string tag, input logic i_busy, input logic i_stall,
                         input logic i_br, input logic [31:0] i_bt,
                         input logic i_trap, input logic i_mret, input logic [31:0] i_epc);
        busy = i_busy; stall = i_stall; br = i_br; bt = i_bt;
        trap = i_trap; mret = i_mret; epc = i_epc;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] rt;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        busy = 0; stall = 0; br = 0; bt = 0; trap = 0; mret = 0; epc = 0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;

        cycle("boot",   0, 0, 0, 0, 0, 0, 0);
        cycle("seq4",   0, 0, 0, 0, 0, 0, 0);
        cycle("seq8",   0, 0, 0, 0, 0, 0, 0);
        cycle("stall1", 0, 1, 0, 0, 0, 0, 0);
        cycle("stall2", 0, 1, 0, 0, 0, 0, 0);
        cycle("br_stl", 0, 1, 1, 32'h40, 0, 0, 0);
        check("br_stl_pc", o_pc[0], 32'h40);

        cycle("bw_br",   1, 0, 1, 32'h80, 0, 0, 0);
        cycle("bw_trap", 1, 0, 0, 0, 1, 0, 0);
        cycle("bw_idle", 1, 0, 0, 0, 0, 0, 0);
        cycle("bw_done", 0, 0, 0, 0, 0, 0, 0);
        check("bw_done_pc", o_pc[0], 32'h100);

        cycle("mis",      0, 0, 1, 32'h42, 0, 0, 0);
        check("mis_pc_chk", o_pc[0], 32'h100);
        check("mis_pc_nochk", o_pc[1], 32'h42);
        cycle("mis_clr",  0, 0, 0, 0, 0, 0, 0);

        cycle("wrap_set", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cycle("wrap",     0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", o_pc[0], 32'h0);
        cycle("mret",     0, 0, 0, 0, 0, 1, 32'h1234);

        for (int i = 0; i < 400; i++) begin
            rt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            cycle("rand", ($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0), rt, ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 11) == 0), rt ^ 32'h0000_1000);
        end

        cycle("pre_rst", 0, 0, 0, 0, 0, 0, 0);
        cycle("rp_set",  1, 0, 1, 32'h500, 0, 0, 0);
        busy = 1;
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        cycle("rst_boot", 0, 0, 0, 0, 0, 0, 0);
        cycle("rst_seq",  0, 0, 0, 0, 0, 0, 0);
        check("rst_no_stale", o_pc[0], 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
